// File: rtl/daq3_trig_seq_if.sv
// ---------------------------------------------------------------------------
// daq3_trig_seq_if
// Bundles the trigger, configuration and status signals of daq3_trig_seq.
//   master : trigger sources and configuration out, status in (controller / bench)
//   slave  : trigger sources and configuration in, status out (daq3_trig_seq)
// Signals:
//   trig_in    asynchronous external trigger
//   soft_trig  one-cycle software trigger
//   arm        level, enables trigger acceptance
//   mode       0 = single-shot, 1 = continuous
//   clr        one-cycle clear of trig_count / overrun
//   period     sequence length in cycles
//   delay      per-channel start offset, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   width      per-channel pulse length, same packing
//   polarity   per-channel, 1 = active-low output
//   pulse_out  registered channel outputs
//   busy       high while a sequence runs
//   trig_count accepted-trigger count (saturating)
//   overrun    sticky, trigger seen while a sequence runs
// ---------------------------------------------------------------------------
interface daq3_trig_seq_if #(
    parameter int NUM_CH    = 3,
    parameter int CNT_WIDTH = 16
);
    logic                          trig_in;
    logic                          soft_trig;
    logic                          arm;
    logic                          mode;
    logic                          clr;
    logic [CNT_WIDTH-1:0]          period;
    logic [NUM_CH*CNT_WIDTH-1:0]   delay;
    logic [NUM_CH*CNT_WIDTH-1:0]   width;
    logic [NUM_CH-1:0]             polarity;
    logic [NUM_CH-1:0]             pulse_out;
    logic                          busy;
    logic [31:0]                   trig_count;
    logic                          overrun;

    modport master (
        output trig_in, soft_trig, arm, mode, clr, period, delay, width, polarity,
        input  pulse_out, busy, trig_count, overrun
    );

    modport slave (
        input  trig_in, soft_trig, arm, mode, clr, period, delay, width, polarity,
        output pulse_out, busy, trig_count, overrun
    );
endinterface

// File: rtl/daq3_trig_seq.sv
// ---------------------------------------------------------------------------
// daq3_trig_seq
// Trigger sequencer: after a trigger event from ARMED it runs a sequence of
// max(period,1) cycles, during which each channel emits one pulse defined by
// its delay/width. Single-shot or continuous (auto-restarting) operation.
// Ports:
//   clk    : block clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : daq3_trig_seq_if.slave (triggers, configuration, status)
// ---------------------------------------------------------------------------
module daq3_trig_seq #(
    parameter int NUM_CH      = 3,
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            resetn,
    daq3_trig_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_WIDTH-1:0]          t_q, t_d;

    // trig_in synchroniser, edge-detect register and post-reset settle mask
    logic [SYNC_STAGES-1:0]        sync_q;
    logic                          prev_q;
    logic [SYNC_STAGES:0]          settle_q;

    // configuration captured on entry to RUN
    logic [CNT_WIDTH-1:0]          period_q;
    logic [NUM_CH*CNT_WIDTH-1:0]   delay_q;
    logic [NUM_CH*CNT_WIDTH-1:0]   width_q;
    logic [NUM_CH-1:0]             pol_q;
    logic                          mode_q;

    logic [31:0]                   trig_count_q;
    logic                          overrun_q;
    logic [NUM_CH-1:0]             pulse_q, pulse_d;

    logic                          trig_event;
    logic                          ext_edge;
    logic                          load;
    logic                          accept;
    logic                          ovr_set;
    logic [CNT_WIDTH-1:0]          last_t;
    logic                          at_last;
    logic [NUM_CH-1:0]             active;

    // The settle mask suppresses the false edge produced when trig_in is
    // already high as the zeroed synchroniser fills after reset.
    assign ext_edge   = sync_q[SYNC_STAGES-1] & ~prev_q & settle_q[SYNC_STAGES];
    assign trig_event = ext_edge | bus.soft_trig;

    // period = 0 behaves as period = 1
    assign last_t  = (period_q == '0) ? '0 : (period_q - CNT_WIDTH'(1));
    assign at_last = (t_q == last_t);

    // Per-channel window; the end bound is one bit wider so delay+width
    // never wraps back into the sequence.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_WIDTH-1:0] ch_delay;
            logic [CNT_WIDTH-1:0] ch_width;
            logic [CNT_WIDTH:0]   ch_end;
            assign ch_delay   = delay_q[gi*CNT_WIDTH +: CNT_WIDTH];
            assign ch_width   = width_q[gi*CNT_WIDTH +: CNT_WIDTH];
            assign ch_end     = {1'b0, ch_delay} + {1'b0, ch_width};
            assign active[gi] = ({1'b0, t_q} >= {1'b0, ch_delay}) &&
                                ({1'b0, t_q} <  ch_end);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        load    = 1'b0;
        accept  = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.arm) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!bus.arm) begin
                    state_d = S_IDLE;
                end else if (trig_event) begin
                    state_d = S_RUN;
                    t_d     = '0;
                    load    = 1'b1;
                    accept  = 1'b1;
                end
            end
            S_RUN: begin
                ovr_set = trig_event;
                if (!bus.arm) begin
                    state_d = S_IDLE;
                    t_d     = '0;
                end else if (at_last) begin
                    t_d = '0;
                    if (!mode_q) begin
                        state_d = S_ARMED;
                    end
                end else begin
                    t_d = t_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase

        // Gating on arm makes the outputs go inactive together with the
        // drop to IDLE rather than one cycle later.
        if (state_q == S_RUN && bus.arm) begin
            pulse_d = active ^ pol_q;
        end else begin
            pulse_d = bus.polarity;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            settle_q     <= '0;
            period_q     <= '0;
            delay_q      <= '0;
            width_q      <= '0;
            pol_q        <= '0;
            mode_q       <= 1'b0;
            trig_count_q <= '0;
            overrun_q    <= 1'b0;
            pulse_q      <= bus.polarity;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.trig_in};
            prev_q   <= sync_q[SYNC_STAGES-1];
            settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
            pulse_q  <= pulse_d;

            if (load) begin
                period_q <= bus.period;
                delay_q  <= bus.delay;
                width_q  <= bus.width;
                pol_q    <= bus.polarity;
                mode_q   <= bus.mode;
            end

            // clr has priority over a coincident increment / overrun set
            if (bus.clr) begin
                trig_count_q <= '0;
            end else if (accept && (trig_count_q != 32'hFFFF_FFFF)) begin
                trig_count_q <= trig_count_q + 32'd1;
            end

            if (bus.clr) begin
                overrun_q <= 1'b0;
            end else if (ovr_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.pulse_out  = pulse_q;
    assign bus.busy       = (state_q == S_RUN);
    assign bus.trig_count = trig_count_q;
    assign bus.overrun    = overrun_q;

endmodule
